// File: rtl/render_pkg.sv
// Shared rendering constants, fragment record and depth-writer FSM states.
package render_pkg;

  localparam int FB_WIDTH  = 320;
  localparam int FB_HEIGHT = 240;
  localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;

  localparam int ADDR_W  = 17;
  localparam int Z_W     = 8;
  localparam int COLOR_W = 12;

  // Farthest representable depth; a cleared z-buffer holds this everywhere.
  localparam logic [Z_W-1:0] Z_FAR = '1;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [Z_W-1:0]     z;
    logic [COLOR_W-1:0] pixel;
  } frag_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_e;

endpackage

// File: rtl/depth_writer.sv
// Pipelined z-test and framebuffer writer with hazard forwarding and full-buffer clear.
module depth_writer #(
  parameter int ADDR_W  = render_pkg::ADDR_W,
  parameter int Z_W     = render_pkg::Z_W,
  parameter int COLOR_W = render_pkg::COLOR_W
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_frag_valid,
  output logic               o_frag_ready,
  input  logic [ADDR_W-1:0]  i_frag_addr,
  input  logic [Z_W-1:0]     i_frag_z,
  input  logic [COLOR_W-1:0] i_frag_pixel,
  input  logic               i_clear_start,
  input  logic [COLOR_W-1:0] i_clear_color,
  output logic               o_clear_busy,
  output logic               o_clear_done,
  output logic [ADDR_W-1:0]  o_zb_raddr,
  input  logic [Z_W-1:0]     i_zb_rdata,
  output logic               o_zb_we,
  output logic [ADDR_W-1:0]  o_zb_waddr,
  output logic [Z_W-1:0]     o_zb_wdata,
  output logic               o_fb_we,
  output logic [ADDR_W-1:0]  o_fb_addr,
  output logic [COLOR_W-1:0] o_fb_pixel,
  output logic [15:0]        o_pass_count,
  output logic [15:0]        o_fail_count
);
  import render_pkg::FB_PIXELS;
  import render_pkg::state_e;
  import render_pkg::IDLE;
  import render_pkg::DRAIN;
  import render_pkg::CLEAR;

  typedef struct packed {
    logic               valid;
    logic [ADDR_W-1:0]  addr;
    logic [Z_W-1:0]     z;
    logic [COLOR_W-1:0] pixel;
  } stage_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_PIXELS - 1);

  state_e             state_q, state_d;
  stage_t             s1_q, s2_q;
  logic               s3_valid_q;
  logic [ADDR_W-1:0]  s3_addr_q;
  logic [Z_W-1:0]     s3_z_q;
  logic [ADDR_W-1:0]  clr_addr_q;
  logic [COLOR_W-1:0] clr_color_q;
  logic               done_q;
  logic [15:0]        pass_cnt_q, fail_cnt_q;

  logic               frag_accept, clear_accept;
  logic               s1_pass, s1_in_range, pipe_empty, clear_last;
  logic [Z_W-1:0]     stored_z;

  assign o_frag_ready = (state_q == IDLE) && i_rst_n;
  assign frag_accept  = i_frag_valid && o_frag_ready;
  assign clear_accept = i_clear_start && o_frag_ready;
  assign o_zb_raddr   = i_rst_n ? i_frag_addr : '0;
  assign pipe_empty   = !s1_q.valid && !s2_q.valid;
  assign clear_last   = (clr_addr_q == LAST_ADDR);
  assign s1_in_range  = (s1_q.addr <= LAST_ADDR);
  assign s1_pass      = (s1_q.z < stored_z);

  // The RAM has not yet seen the writes sitting in S2 (this cycle) or S3
  // (written last cycle, after our read-first fetch), so those take priority.
  always_comb begin
    stored_z = i_zb_rdata;
    if (s2_q.valid && (s2_q.addr == s1_q.addr))      stored_z = s2_q.z;
    else if (s3_valid_q && (s3_addr_q == s1_q.addr)) stored_z = s3_z_q;
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_clear_start) state_d = DRAIN;
      DRAIN:   if (pipe_empty)    state_d = CLEAR;
      CLEAR:   if (clear_last)    state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_comb begin
    o_zb_we    = 1'b0;
    o_zb_waddr = '0;
    o_zb_wdata = '0;
    o_fb_we    = 1'b0;
    o_fb_addr  = '0;
    o_fb_pixel = '0;
    if (state_q == CLEAR) begin
      o_zb_we    = 1'b1;
      o_zb_waddr = clr_addr_q;
      o_zb_wdata = '1;
      o_fb_we    = 1'b1;
      o_fb_addr  = clr_addr_q;
      o_fb_pixel = clr_color_q;
    end else if (s2_q.valid) begin
      o_zb_we    = 1'b1;
      o_zb_waddr = s2_q.addr;
      o_zb_wdata = s2_q.z;
      o_fb_we    = 1'b1;
      o_fb_addr  = s2_q.addr;
      o_fb_pixel = s2_q.pixel;
    end
    o_clear_busy = (state_q == DRAIN) || (state_q == CLEAR);
    o_clear_done = done_q;
    o_pass_count = pass_cnt_q;
    o_fail_count = fail_cnt_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_q        <= '0;
      s2_q        <= '0;
      s3_valid_q  <= 1'b0;
      s3_addr_q   <= '0;
      s3_z_q      <= '0;
      clr_addr_q  <= '0;
      clr_color_q <= '0;
      done_q      <= 1'b0;
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
    end else begin
      s1_q       <= '{valid: frag_accept, addr: i_frag_addr, z: i_frag_z, pixel: i_frag_pixel};
      // Out-of-range fragments still get a depth verdict but never reach a strobe.
      s2_q       <= '{valid: s1_q.valid && s1_pass && s1_in_range,
                      addr: s1_q.addr, z: s1_q.z, pixel: s1_q.pixel};
      s3_valid_q <= s2_q.valid;
      s3_addr_q  <= s2_q.addr;
      s3_z_q     <= s2_q.z;

      if (state_q == DRAIN)      clr_addr_q <= '0;
      else if (state_q == CLEAR) clr_addr_q <= clr_addr_q + ADDR_W'(1);
      if (clear_accept) clr_color_q <= i_clear_color;
      done_q <= (state_q == CLEAR) && clear_last;

      if (clear_accept) begin
        pass_cnt_q <= '0;
        fail_cnt_q <= '0;
      end else if (s1_q.valid) begin
        if (s1_pass) begin
          if (pass_cnt_q != 16'hFFFF) pass_cnt_q <= pass_cnt_q + 16'd1;
        end else begin
          if (fail_cnt_q != 16'hFFFF) fail_cnt_q <= fail_cnt_q + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_depth_writer.sv
// Self-checking bench: read-first z-RAM model, serial depth model feeding a write scoreboard.
module tb_depth_writer;
  import render_pkg::*;

  logic               i_clk, i_rst_n;
  logic               i_frag_valid, o_frag_ready;
  logic [ADDR_W-1:0]  i_frag_addr;
  logic [Z_W-1:0]     i_frag_z;
  logic [COLOR_W-1:0] i_frag_pixel;
  logic               i_clear_start;
  logic [COLOR_W-1:0] i_clear_color;
  logic               o_clear_busy, o_clear_done;
  logic [ADDR_W-1:0]  o_zb_raddr;
  logic [Z_W-1:0]     i_zb_rdata;
  logic               o_zb_we, o_fb_we;
  logic [ADDR_W-1:0]  o_zb_waddr, o_fb_addr;
  logic [Z_W-1:0]     o_zb_wdata;
  logic [COLOR_W-1:0] o_fb_pixel;
  logic [15:0]        o_pass_count, o_fail_count;

  depth_writer dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_frag_valid(i_frag_valid), .o_frag_ready(o_frag_ready),
    .i_frag_addr(i_frag_addr), .i_frag_z(i_frag_z), .i_frag_pixel(i_frag_pixel),
    .i_clear_start(i_clear_start), .i_clear_color(i_clear_color),
    .o_clear_busy(o_clear_busy), .o_clear_done(o_clear_done),
    .o_zb_raddr(o_zb_raddr), .i_zb_rdata(i_zb_rdata),
    .o_zb_we(o_zb_we), .o_zb_waddr(o_zb_waddr), .o_zb_wdata(o_zb_wdata),
    .o_fb_we(o_fb_we), .o_fb_addr(o_fb_addr), .o_fb_pixel(o_fb_pixel),
    .o_pass_count(o_pass_count), .o_fail_count(o_fail_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_pass = 0, n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Read-first z-buffer: data for the address presented in cycle N appears in N+1.
  logic [Z_W-1:0] zram [FB_PIXELS];
  always @(posedge i_clk) begin
    i_zb_rdata <= (o_zb_raddr < FB_PIXELS) ? zram[o_zb_raddr] : 8'hFF;
    if (o_zb_we === 1'b1 && o_zb_waddr < FB_PIXELS) zram[o_zb_waddr] = o_zb_wdata;
  end

  int cyc = 0;
  always @(posedge i_clk) cyc++;

  // Serial reference model and write scoreboard.
  typedef struct {
    frag_t frag;
    int    cyc;
  } exp_t;
  exp_t           sb[$];
  exp_t           e;
  logic [Z_W-1:0] mz [FB_PIXELS];
  int             m_pass = 0, m_fail = 0;

  int                 wr_count = 0;
  bit                 clear_mode = 0;
  logic [ADDR_W-1:0]  clr_expect;
  logic [COLOR_W-1:0] clr_color_exp;
  int                 clr_seen, clr_errs;

  always @(negedge i_clk) begin
    if (o_zb_we === 1'b1 || o_fb_we === 1'b1) begin
      wr_count++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("wr_strobes", {o_zb_we, o_fb_we}, 2'b11);
        check("wr_zaddr", o_zb_waddr, e.frag.addr);
        check("wr_faddr", o_fb_addr, e.frag.addr);
        check("wr_z", o_zb_wdata, e.frag.z);
        check("wr_pixel", o_fb_pixel, e.frag.pixel);
        check("wr_latency", cyc, e.cyc);
      end else if (clear_mode) begin
        if (!(o_zb_we === 1'b1 && o_fb_we === 1'b1) || o_zb_waddr !== clr_expect ||
            o_fb_addr !== clr_expect || o_zb_wdata !== 8'hFF || o_fb_pixel !== clr_color_exp)
          clr_errs++;
        clr_expect++;
        clr_seen++;
      end else begin
        check("unexpected_write_addr", o_zb_waddr, 32'hDEAD_BEEF);
      end
    end
  end

  task automatic send(input logic [ADDR_W-1:0] a, input logic [Z_W-1:0] z, input logic [COLOR_W-1:0] p);
    exp_t x;
    i_frag_valid = 1'b1;
    i_frag_addr  = a;
    i_frag_z     = z;
    i_frag_pixel = p;
    check("frag_ready", o_frag_ready, 1'b1);
    if (a < FB_PIXELS) begin
      if (z < mz[a]) begin
        x.frag = '{addr: a, z: z, pixel: p};
        x.cyc  = cyc + 2;
        sb.push_back(x);
        mz[a] = z;
        m_pass++;
      end else begin
        m_fail++;
      end
    end
    @(posedge i_clk); #1;
    i_frag_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clk); #1;
    end
  endtask

  task automatic gap_pair(input int gap, input logic [Z_W-1:0] z1, input logic [Z_W-1:0] z2,
                          input int exp_writes, input int exp_fails);
    int w0, f0;
    zram[5] = 8'hFF;
    mz[5]   = 8'hFF;
    w0 = wr_count;
    f0 = m_fail;
    send(17'd5, z1, 12'h111);
    idle(gap);
    send(17'd5, z2, 12'h222);
    idle(4);
    check($sformatf("gap%0d_writes", gap), wr_count - w0, exp_writes);
    check($sformatf("gap%0d_fail_delta", gap), m_fail - f0, exp_fails);
    check($sformatf("gap%0d_fail_cnt", gap), o_fail_count, m_fail);
    check($sformatf("gap%0d_ram_z", gap), zram[5], mz[5]);
  endtask

  typedef struct {
    logic [ADDR_W-1:0]  addr;
    logic [Z_W-1:0]     init_z;
    logic [Z_W-1:0]     z;
    logic [COLOR_W-1:0] pixel;
    int                 exp_writes;
  } vec_t;
  vec_t vecs[7];

  initial begin
    int  w0;
    bit  got_done, hit;

    vecs[0] = '{17'd100,   8'h80, 8'h40, 12'hF00, 1};
    vecs[1] = '{17'd100,   8'h80, 8'h80, 12'h0F0, 0};
    vecs[2] = '{17'd200,   8'h80, 8'h81, 12'h00F, 0};
    vecs[3] = '{17'd0,     8'hFF, 8'hFE, 12'h123, 1};
    vecs[4] = '{17'd76799, 8'hFF, 8'h00, 12'hABC, 1};
    vecs[5] = '{17'd300,   8'h00, 8'h00, 12'h555, 0};
    vecs[6] = '{17'd400,   8'h01, 8'h00, 12'h777, 1};

    for (int i = 0; i < FB_PIXELS; i++) begin
      zram[i] = 8'hFF;
      mz[i]   = 8'hFF;
    end

    // Reset with live-looking inputs: everything must still read as zero.
    i_rst_n       = 1'b0;
    i_frag_valid  = 1'b1;
    i_frag_addr   = 17'h1234;
    i_frag_z      = 8'h00;
    i_frag_pixel  = 12'hFFF;
    i_clear_start = 1'b1;
    i_clear_color = 12'h000;
    repeat (3) @(negedge i_clk);
    check("rst_ready", o_frag_ready, 1'b0);
    check("rst_we", {o_zb_we, o_fb_we}, 2'b00);
    check("rst_raddr", o_zb_raddr, 17'd0);
    check("rst_waddr", o_zb_waddr, 17'd0);
    check("rst_busy_done", {o_clear_busy, o_clear_done}, 2'b00);
    check("rst_counts", {o_pass_count, o_fail_count}, 32'd0);
    i_frag_valid  = 1'b0;
    i_clear_start = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    check("idle_ready", o_frag_ready, 1'b1);

    for (int i = 0; i < 7; i++) begin
      zram[vecs[i].addr] = vecs[i].init_z;
      mz[vecs[i].addr]   = vecs[i].init_z;
      w0 = wr_count;
      send(vecs[i].addr, vecs[i].z, vecs[i].pixel);
      idle(4);
      check($sformatf("vec%0d_writes", i), wr_count - w0, vecs[i].exp_writes);
      check($sformatf("vec%0d_pass_cnt", i), o_pass_count, m_pass);
      check($sformatf("vec%0d_fail_cnt", i), o_fail_count, m_fail);
      check($sformatf("vec%0d_sb_empty", i), sb.size(), 0);
    end

    // Same-address hazards: farther second fragment must lose at every spacing.
    gap_pair(0, 8'h50, 8'h60, 1, 1);
    gap_pair(1, 8'h50, 8'h60, 1, 1);
    gap_pair(2, 8'h50, 8'h60, 1, 1);
    gap_pair(0, 8'h50, 8'h40, 2, 0);
    gap_pair(1, 8'h50, 8'h50, 1, 1);

    // Out-of-range fragment must never produce a strobe.
    w0 = wr_count;
    send(17'd76800, 8'h00, 12'hFFF);
    idle(4);
    check("oob_writes", wr_count - w0, 0);

    // Clear with a fragment accepted in the same cycle as the start.
    clear_mode    = 1;
    clr_expect    = '0;
    clr_seen      = 0;
    clr_errs      = 0;
    clr_color_exp = 12'h00F;
    zram[7] = 8'hFF;
    mz[7]   = 8'hFF;
    m_pass  = 0;
    m_fail  = 0;
    i_clear_start = 1'b1;
    i_clear_color = 12'h00F;
    send(17'd7, 8'h10, 12'h0AB);
    i_clear_start = 1'b0;
    i_clear_color = 12'h000;
    check("ready_low_after_start", o_frag_ready, 1'b0);
    check("busy_after_start", o_clear_busy, 1'b1);
    got_done = 0;
    for (int i = 0; i < 80000 && !got_done; i++) begin
      @(negedge i_clk);
      if (i == 100) begin
        i_clear_start = 1'b1;
        i_clear_color = 12'hF0F;
      end else if (i == 101) begin
        i_clear_start = 1'b0;
      end
      if (o_clear_done === 1'b1) got_done = 1;
    end
    check("clear_done_seen", got_done, 1'b1);
    check("ready_at_done", o_frag_ready, 1'b1);
    check("busy_at_done", o_clear_busy, 1'b0);
    check("clear_write_count", clr_seen, FB_PIXELS);
    check("clear_write_errs", clr_errs, 0);
    check("clear_sb_empty", sb.size(), 0);
    check("pass_after_clear", o_pass_count, m_pass);
    check("fail_after_clear", o_fail_count, m_fail);
    @(negedge i_clk);
    check("done_one_cycle", o_clear_done, 1'b0);
    repeat (3) @(negedge i_clk);
    check("no_restart_busy", o_clear_busy, 1'b0);
    clear_mode = 0;
    for (int i = 0; i < FB_PIXELS; i++) mz[i] = 8'hFF;

    @(posedge i_clk); #1;
    send(17'd100, 8'hFE, 12'h321);
    idle(4);
    check("post_clear_sb_empty", sb.size(), 0);
    check("post_clear_ram", zram[100], 8'hFE);

    // Reset in the middle of a clear.
    clear_mode    = 1;
    clr_expect    = '0;
    clr_color_exp = 12'h0F0;
    i_clear_start = 1'b1;
    i_clear_color = 12'h0F0;
    @(posedge i_clk); #1;
    i_clear_start = 1'b0;
    hit = 0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge i_clk);
      if (o_zb_we === 1'b1 && o_zb_waddr == 17'd1000) hit = 1;
    end
    check("reached_addr_1000", hit, 1'b1);
    i_rst_n = 1'b0;
    #1;
    check("midrst_we", {o_zb_we, o_fb_we}, 2'b00);
    check("midrst_busy", o_clear_busy, 1'b0);
    check("midrst_ready", o_frag_ready, 1'b0);
    check("midrst_counts", {o_pass_count, o_fail_count}, 32'd0);
    w0 = wr_count;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (6) @(negedge i_clk);
    check("after_rst_writes", wr_count - w0, 0);
    check("after_rst_ready", o_frag_ready, 1'b1);
    check("after_rst_busy_done", {o_clear_busy, o_clear_done}, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
